// File: rtl/memmu_pointcloud_pingpong.sv
// Multi-cloud ping/pong point-cloud address generator.
// Each cloud fills one buffer while the other is held for ExMU.
module memmu_pointcloud_pingpong #(
  parameter int NUM_CLOUDS       = 2,
  parameter int ADDR_W           = 32,
  parameter int PAYLOAD_W        = 64,
  parameter int POINT_BYTES_LOG2 = 4,
  parameter int MAX_POINTS_LOG2  = 16,
  localparam int CSEL_W = (NUM_CLOUDS > 1) ? $clog2(NUM_CLOUDS) : 1,
  localparam int SIZE_W = MAX_POINTS_LOG2 + 1
) (
  input  logic                         i_SYSTEM_clk,
  input  logic                         i_SYSTEM_rst,
  input  logic [ADDR_W-1:0]            i_MonU_baseAddr,
  input  logic                         i_MonU_clearFlags,
  input  logic                         i_SIU_valid,
  output logic                         o_SIU_ready,
  input  logic [CSEL_W-1:0]            i_SIU_cloudSel,
  input  logic                         i_SIU_newFrame,
  input  logic [PAYLOAD_W-1:0]         i_SIU_payload,
  output logic                         o_MEM_wrValid,
  input  logic                         i_MEM_wrReady,
  output logic [ADDR_W-1:0]            o_MEM_wrAddress,
  output logic [PAYLOAD_W-1:0]         o_MEM_wrPayload,
  output logic [NUM_CLOUDS-1:0]        o_MemMU_frameValid,
  output logic [NUM_CLOUDS*ADDR_W-1:0] o_MemMU_readBase,
  output logic [NUM_CLOUDS*SIZE_W-1:0] o_MemMU_size,
  input  logic [NUM_CLOUDS-1:0]        i_ExMU_release,
  output logic [NUM_CLOUDS-1:0]        o_MemMU_overflow,
  output logic [NUM_CLOUDS-1:0]        o_MemMU_overrun
);

  localparam int BUF_BYTES_LOG2 = MAX_POINTS_LOG2 + POINT_BYTES_LOG2;
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;
  localparam logic [SIZE_W-1:0] FULL = {1'b1, {MAX_POINTS_LOG2{1'b0}}};

  logic [NUM_CLOUDS-1:0]             state_q, state_d;
  logic [NUM_CLOUDS-1:0]             wbuf_q, wbuf_d;
  logic [NUM_CLOUDS-1:0][SIZE_W-1:0] wptr_q, wptr_d;
  logic [NUM_CLOUDS-1:0][ADDR_W-1:0] rbase_q, rbase_d;
  logic [NUM_CLOUDS-1:0][SIZE_W-1:0] size_q, size_d;
  logic [NUM_CLOUDS-1:0]             ovf_q, ovf_d, ovf_set;
  logic [NUM_CLOUDS-1:0]             ovr_q, ovr_d, ovr_set;
  logic                              wrv_q, wrv_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [PAYLOAD_W-1:0]              pl_q, pl_d;

  logic              acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rel;
  logic              buf_n;
  logic [SIZE_W-1:0] ptr_n;

  function automatic logic [ADDR_W-1:0] buf_base(
    input logic [ADDR_W-1:0] base,
    input int                c,
    input logic              b
  );
    logic [ADDR_W-1:0] idx;
    idx = ADDR_W'(2 * c) | ADDR_W'(b);
    return base + (idx << BUF_BYTES_LOG2);
  endfunction

  // Reset also forces ready low so every output reads 0 while held in reset.
  assign o_SIU_ready = !i_SYSTEM_rst && (!wrv_q || i_MEM_wrReady);
  assign acc         = i_SIU_valid && o_SIU_ready;

  always_comb begin
    state_d = state_q;
    wbuf_d  = wbuf_q;
    wptr_d  = wptr_q;
    rbase_d = rbase_q;
    size_d  = size_q;
    ovf_set = '0;
    ovr_set = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    rel     = 1'b0;
    buf_n   = 1'b0;
    ptr_n   = '0;
    for (int c = 0; c < NUM_CLOUDS; c++) begin
      rel = i_ExMU_release[c] && (state_q[c] == ST_HELD);
      if (rel) state_d[c] = ST_FILL;
      if (acc && (i_SIU_cloudSel == CSEL_W'(c))) begin
        buf_n = wbuf_q[c];
        ptr_n = wptr_q[c];
        if (i_SIU_newFrame) begin
          ptr_n = '0;
          if (wptr_q[c] != '0) begin
            // A release in the same cycle frees the slot before the swap.
            if ((state_q[c] == ST_HELD) && !rel) begin
              ovr_set[c] = 1'b1;
            end else begin
              size_d[c]  = wptr_q[c];
              rbase_d[c] = buf_base(i_MonU_baseAddr, c, wbuf_q[c]);
              buf_n      = ~wbuf_q[c];
              state_d[c] = ST_HELD;
            end
          end
        end
        wbuf_d[c] = buf_n;
        wptr_d[c] = ptr_n;
        if (ptr_n == FULL) begin
          ovf_set[c] = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = buf_base(i_MonU_baseAddr, c, buf_n)
                    + (ADDR_W'(ptr_n) << POINT_BYTES_LOG2);
          wptr_d[c] = ptr_n + SIZE_W'(1);
        end
      end
    end
  end

  always_comb begin
    ovf_d = (ovf_q & ~{NUM_CLOUDS{i_MonU_clearFlags}}) | ovf_set;
    ovr_d = (ovr_q & ~{NUM_CLOUDS{i_MonU_clearFlags}}) | ovr_set;
  end

  always_comb begin
    wrv_d  = wrv_q;
    addr_d = addr_q;
    pl_d   = pl_q;
    if (wr_en) begin
      wrv_d  = 1'b1;
      addr_d = wr_addr;
      pl_d   = i_SIU_payload;
    end else if (i_MEM_wrReady) begin
      wrv_d = 1'b0;
    end
  end

  always_ff @(posedge i_SYSTEM_clk or posedge i_SYSTEM_rst) begin
    if (i_SYSTEM_rst) begin
      state_q <= {NUM_CLOUDS{ST_FILL}};
      wbuf_q  <= '0;
      wptr_q  <= '0;
      rbase_q <= '0;
      size_q  <= '0;
      ovf_q   <= '0;
      ovr_q   <= '0;
      wrv_q   <= 1'b0;
      addr_q  <= '0;
      pl_q    <= '0;
    end else begin
      state_q <= state_d;
      wbuf_q  <= wbuf_d;
      wptr_q  <= wptr_d;
      rbase_q <= rbase_d;
      size_q  <= size_d;
      ovf_q   <= ovf_d;
      ovr_q   <= ovr_d;
      wrv_q   <= wrv_d;
      addr_q  <= addr_d;
      pl_q    <= pl_d;
    end
  end

  assign o_MEM_wrValid      = wrv_q;
  assign o_MEM_wrAddress    = addr_q;
  assign o_MEM_wrPayload    = pl_q;
  assign o_MemMU_frameValid = state_q;
  assign o_MemMU_readBase   = rbase_q;
  assign o_MemMU_size       = size_q;
  assign o_MemMU_overflow   = ovf_q;
  assign o_MemMU_overrun    = ovr_q;

endmodule

// File: tb/tb_memmu_pointcloud_pingpong.sv
// Directed bench for memmu_pointcloud_pingpong.
// DUT a uses default sizing, DUT b a 4-slot buffer for overflow.
module tb_memmu_pointcloud_pingpong;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- DUT a ----------------
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [0:0]  a_sel = '0;
  logic        a_nf = 1'b0;
  logic [63:0] a_pl = '0;
  logic        a_wrv;
  logic        a_wrr = 1'b1;
  logic [31:0] a_wra;
  logic [63:0] a_wrp;
  logic [1:0]  a_fv;
  logic [63:0] a_rb;
  logic [33:0] a_sz;
  logic [1:0]  a_rel = '0;
  logic [1:0]  a_ovf;
  logic [1:0]  a_ovr;

  memmu_pointcloud_pingpong u_a (
    .i_SYSTEM_clk       (clk),
    .i_SYSTEM_rst       (rst),
    .i_MonU_baseAddr    (32'h1000_0000),
    .i_MonU_clearFlags  (clr),
    .i_SIU_valid        (a_valid),
    .o_SIU_ready        (a_ready),
    .i_SIU_cloudSel     (a_sel),
    .i_SIU_newFrame     (a_nf),
    .i_SIU_payload      (a_pl),
    .o_MEM_wrValid      (a_wrv),
    .i_MEM_wrReady      (a_wrr),
    .o_MEM_wrAddress    (a_wra),
    .o_MEM_wrPayload    (a_wrp),
    .o_MemMU_frameValid (a_fv),
    .o_MemMU_readBase   (a_rb),
    .o_MemMU_size       (a_sz),
    .i_ExMU_release     (a_rel),
    .o_MemMU_overflow   (a_ovf),
    .o_MemMU_overrun    (a_ovr)
  );

  // ---------------- DUT b ----------------
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [0:0]  b_sel = '0;
  logic        b_nf = 1'b0;
  logic [63:0] b_pl = '0;
  logic        b_wrv;
  logic        b_wrr = 1'b1;
  logic [31:0] b_wra;
  logic [63:0] b_wrp;
  logic [1:0]  b_fv;
  logic [63:0] b_rb;
  logic [5:0]  b_sz;
  logic [1:0]  b_rel = '0;
  logic [1:0]  b_ovf;
  logic [1:0]  b_ovr;

  memmu_pointcloud_pingpong #(.MAX_POINTS_LOG2(2)) u_b (
    .i_SYSTEM_clk       (clk),
    .i_SYSTEM_rst       (rst),
    .i_MonU_baseAddr    (32'h2000_0000),
    .i_MonU_clearFlags  (clr),
    .i_SIU_valid        (b_valid),
    .o_SIU_ready        (b_ready),
    .i_SIU_cloudSel     (b_sel),
    .i_SIU_newFrame     (b_nf),
    .i_SIU_payload      (b_pl),
    .o_MEM_wrValid      (b_wrv),
    .i_MEM_wrReady      (b_wrr),
    .o_MEM_wrAddress    (b_wra),
    .o_MEM_wrPayload    (b_wrp),
    .o_MemMU_frameValid (b_fv),
    .o_MemMU_readBase   (b_rb),
    .o_MemMU_size       (b_sz),
    .i_ExMU_release     (b_rel),
    .o_MemMU_overflow   (b_ovf),
    .o_MemMU_overrun    (b_ovr)
  );

  logic [95:0] qa[$];
  logic [95:0] qb[$];

  task automatic chk(input string tag, input logic [95:0] obs,
                     input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pops: handshake seen at negedge completes at next posedge.
  logic        stall_q = 1'b0;
  logic [95:0] stall_v = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (a_wrv && a_wrr) begin
        if (qa.size() == 0) chk("a_unexpected_write", {a_wra, a_wrp}, '0);
        else chk("a_write", {a_wra, a_wrp}, qa.pop_front());
      end
      if (a_wrv && !a_wrr) begin
        if (stall_q) chk("a_stall_stable", {a_wra, a_wrp}, stall_v);
        stall_q = 1'b1;
        stall_v = {a_wra, a_wrp};
      end else begin
        stall_q = 1'b0;
      end
      if (b_wrv && b_wrr) begin
        if (qb.size() == 0) chk("b_unexpected_write", {b_wra, b_wrp}, '0);
        else chk("b_write", {b_wra, b_wrp}, qb.pop_front());
      end
    end
  end

  task automatic send_a(input logic c, input logic nf, input logic [63:0] pl,
                        input logic wr, input logic [31:0] addr,
                        input logic [1:0] rel);
    int n;
    a_valid = 1'b1;
    a_sel   = c;
    a_nf    = nf;
    a_pl    = pl;
    a_rel   = rel;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a_ready && n < 20);
    if (!a_ready) chk("a_siu_ready_timeout", {95'd0, a_ready}, 96'd1);
    else if (wr) qa.push_back({addr, pl});
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_nf    = 1'b0;
    a_rel   = '0;
  endtask

  task automatic send_b(input logic nf, input logic [63:0] pl,
                        input logic wr, input logic [31:0] addr);
    b_valid = 1'b1;
    b_sel   = 1'b0;
    b_nf    = nf;
    b_pl    = pl;
    @(negedge clk);
    if (!b_ready) chk("b_siu_ready", {95'd0, b_ready}, 96'd1);
    else if (wr) qb.push_back({addr, pl});
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_nf    = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wrValid", {95'd0, a_wrv}, 96'd0);
    chk("rst_ready", {95'd0, a_ready}, 96'd0);
    chk("rst_frameValid", {94'd0, a_fv}, 96'd0);
    chk("rst_readBase", {32'd0, a_rb}, 96'd0);
    chk("rst_size", {62'd0, a_sz}, 96'd0);
    chk("rst_flags", {92'd0, a_ovf, a_ovr}, 96'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // cloud0: 3 points, then a new frame swaps buffers
    send_a(1'b0, 1'b1, 64'hA0, 1'b1, 32'h1000_0000, 2'b00);
    send_a(1'b0, 1'b0, 64'hA1, 1'b1, 32'h1000_0010, 2'b00);
    send_a(1'b0, 1'b0, 64'hA2, 1'b1, 32'h1000_0020, 2'b00);
    send_a(1'b0, 1'b1, 64'hA3, 1'b1, 32'h1010_0000, 2'b00);
    chk("c0_frameValid", {94'd0, a_fv}, 96'd1);
    chk("c0_size", {79'd0, a_sz[16:0]}, 96'd3);
    chk("c0_readBase", {64'd0, a_rb[31:0]}, 96'h1000_0000);
    repeat (2) @(posedge clk);
    #1;

    // back-pressure for 5 cycles with a beat waiting
    a_wrr = 1'b0;
    send_a(1'b0, 1'b0, 64'hB0, 1'b1, 32'h1010_0010, 2'b00);
    fork
      send_a(1'b0, 1'b0, 64'hB1, 1'b1, 32'h1010_0020, 2'b00);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_ready", {95'd0, a_ready}, 96'd0);
          chk("stall_addr", {64'd0, a_wra}, 96'h1010_0010);
        end
        @(posedge clk);
        #1;
        a_wrr = 1'b1;
      end
    join
    send_a(1'b0, 1'b0, 64'hB2, 1'b1, 32'h1010_0030, 2'b00);

    // second new frame while still held: overrun, restart
    send_a(1'b0, 1'b1, 64'hC0, 1'b1, 32'h1010_0000, 2'b00);
    chk("ovr_flag", {94'd0, a_ovr}, 96'd1);
    chk("ovr_size", {79'd0, a_sz[16:0]}, 96'd3);
    chk("ovr_readBase", {64'd0, a_rb[31:0]}, 96'h1000_0000);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk("ovr_cleared", {94'd0, a_ovr}, 96'd0);

    // cloud1: publish, then release+newFrame in the same cycle
    send_a(1'b1, 1'b1, 64'hD0, 1'b1, 32'h1020_0000, 2'b00);
    send_a(1'b1, 1'b0, 64'hD1, 1'b1, 32'h1020_0010, 2'b00);
    send_a(1'b1, 1'b1, 64'hD2, 1'b1, 32'h1030_0000, 2'b00);
    chk("c1_frameValid", {94'd0, a_fv}, 96'd3);
    chk("c1_size", {79'd0, a_sz[33:17]}, 96'd2);
    chk("c1_readBase", {64'd0, a_rb[63:32]}, 96'h1020_0000);
    send_a(1'b1, 1'b0, 64'hD3, 1'b1, 32'h1030_0010, 2'b00);
    send_a(1'b1, 1'b0, 64'hD4, 1'b1, 32'h1030_0020, 2'b00);
    send_a(1'b1, 1'b1, 64'hD5, 1'b1, 32'h1020_0000, 2'b10);
    chk("relswap_frameValid", {94'd0, a_fv}, 96'd3);
    chk("relswap_size", {79'd0, a_sz[33:17]}, 96'd3);
    chk("relswap_readBase", {64'd0, a_rb[63:32]}, 96'h1030_0000);
    a_rel = 2'b11;
    @(posedge clk);
    #1;
    a_rel = 2'b00;
    chk("release_both", {94'd0, a_fv}, 96'd0);

    // DUT b: 4-slot buffers, 6 beats in one frame
    send_b(1'b1, 64'hE0, 1'b1, 32'h2000_0000);
    send_b(1'b0, 64'hE1, 1'b1, 32'h2000_0010);
    send_b(1'b0, 64'hE2, 1'b1, 32'h2000_0020);
    send_b(1'b0, 64'hE3, 1'b1, 32'h2000_0030);
    send_b(1'b0, 64'hE4, 1'b0, 32'h0);
    send_b(1'b0, 64'hE5, 1'b0, 32'h0);
    chk("b_overflow", {94'd0, b_ovf}, 96'd1);
    send_b(1'b1, 64'hE6, 1'b1, 32'h2000_0040);
    chk("b_frameValid", {94'd0, b_fv}, 96'd1);
    chk("b_size", {93'd0, b_sz[2:0]}, 96'd4);
    chk("b_readBase", {64'd0, b_rb[31:0]}, 96'h2000_0000);
    repeat (2) @(posedge clk);
    #1;

    // async reset while a write is pending (pending write is dropped)
    a_wrr = 1'b0;
    send_a(1'b0, 1'b1, 64'hF0, 1'b0, 32'h0, 2'b00);
    chk("pre_rst_wrValid", {95'd0, a_wrv}, 96'd1);
    chk("pre_rst_frameValid", {94'd0, a_fv}, 96'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_wrValid", {95'd0, a_wrv}, 96'd0);
    chk("async_ready", {95'd0, a_ready}, 96'd0);
    chk("async_frameValid", {94'd0, a_fv}, 96'd0);
    chk("async_readBase", {32'd0, a_rb}, 96'd0);
    chk("async_b_overflow", {94'd0, b_ovf}, 96'd0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    a_wrr = 1'b1;
    send_a(1'b0, 1'b1, 64'h55, 1'b1, 32'h1000_0000, 2'b00);

    repeat (4) @(posedge clk);
    #1;
    chk("a_queue_drained", 96'(qa.size()), 96'd0);
    chk("b_queue_drained", 96'(qb.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
